// File: rtl/evt_counter_pkg.sv
// Shared types for the multi-channel event counter.
// Optional snapshot feature of evt_counter_multi: EVT_COUNTER_MULTI_SNAPSHOT_EN.
package evt_counter_pkg;

    // Count direction of one channel.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Per-lane control bundle after cascade muxing.
    typedef struct packed {
        logic evt;
        dir_e dir;
        logic load;
    } lane_ctrl_t;

    // Count width for a given count range; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/evt_counter_lane.sv
// One counter channel: load/up/down with runtime terminal value, wrap pulse
// and a combinational carry for chaining into the next channel.
module evt_counter_lane
    import evt_counter_pkg::*;
#(
    parameter int unsigned CW          = 7,
    parameter int unsigned COUNT_START = 0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  lane_ctrl_t    ctrl_in,
    input  logic [CW-1:0] load_val_in,
    input  logic [CW-1:0] limit_in,
    output logic [CW-1:0] count_out,
    output logic          wrap_out,
    output logic          carry_c
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wrap_q;
    logic          wrap_d;
    logic          wrap_cond_c;

    // An event would wrap: bottom reached going down, or at/above the limit going up.
    always_comb begin
        wrap_cond_c = 1'b0;
        if (ctrl_in.dir == DIR_DOWN) begin
            wrap_cond_c = (count_q == '0);
        end else begin
            wrap_cond_c = (count_q >= limit_in);
        end
    end

    assign carry_c = ctrl_in.evt & ~ctrl_in.load & wrap_cond_c;

    // Next count: load beats event; wrapping events reload the far end.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (ctrl_in.load) begin
            count_d = load_val_in;
        end else if (ctrl_in.evt) begin
            if (wrap_cond_c) begin
                wrap_d  = 1'b1;
                count_d = (ctrl_in.dir == DIR_DOWN) ? limit_in : '0;
            end else if (ctrl_in.dir == DIR_DOWN) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count and wrap-pulse registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= CW'(COUNT_START);
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = count_q;
    assign wrap_out  = wrap_q;

endmodule

// File: rtl/evt_counter_multi.sv
// Multi-channel event counter with optional cascade into one multi-digit counter.
// Optional snapshot register bank enabled by macro EVT_COUNTER_MULTI_SNAPSHOT_EN.
module evt_counter_multi
    import evt_counter_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned MAX_COUNT   = 128,
    parameter  int unsigned COUNT_START = 0,
    parameter  int unsigned CASCADE     = 0,
    localparam int unsigned CW          = cnt_width(MAX_COUNT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] evt_in,
    input  logic [NUM_CH-1:0] dir_in,
    input  logic [NUM_CH-1:0] load_in,
    input  logic [CW-1:0]     load_val_in,
    input  logic [CW-1:0]     limit_in,
`ifdef EVT_COUNTER_MULTI_SNAPSHOT_EN
    input  logic              snap_in,
    output logic [CW-1:0]     snap_out [NUM_CH],
`endif
    output logic [CW-1:0]     count_out [NUM_CH],
    output logic [NUM_CH-1:0] wrap_out
);

    // Lanes; in cascade mode each lane above 0 is driven by the carry below it.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic       eff_evt;
        logic       carry;
        lane_ctrl_t ctrl;

        if (i == 0) begin : g_head
            assign eff_evt = evt_in[i];
        end else begin : g_chain
            assign eff_evt = (CASCADE != 0) ? g_lane[i-1].carry : evt_in[i];
        end

        assign ctrl = '{evt: eff_evt, dir: dir_e'(dir_in[i]), load: load_in[i]};

        evt_counter_lane #(
            .CW          (CW),
            .COUNT_START (COUNT_START)
        ) u_lane (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .ctrl_in     (ctrl),
            .load_val_in (load_val_in),
            .limit_in    (limit_in),
            .count_out   (count_out[i]),
            .wrap_out    (wrap_out[i]),
            .carry_c     (carry)
        );
    end

    // Carry out of the top lane has no consumer.
    logic carry_top_unused;
    assign carry_top_unused = g_lane[NUM_CH-1].carry;

`ifdef EVT_COUNTER_MULTI_SNAPSHOT_EN
    logic [CW-1:0] snap_q [NUM_CH];
    logic [CW-1:0] snap_d [NUM_CH];

    // Capture the pre-update counts of all lanes together.
    always_comb begin
        snap_d = snap_q;
        if (snap_in) begin
            snap_d = count_out;
        end
    end

    // Snapshot register bank, cleared on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            snap_q <= '{default: '0};
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_out = snap_q;
`endif

endmodule
